cond_logic_unit: RTL and testbench
==================================

// Module: cond_logic_unit
// PURPOSE
//  Consumes the ALU's {N,Z,C,V} result flags, holds the architectural flag register and evaluates ARM condition codes.
//  Gates write/branch strobes from the decoder so only condition-passing instructions commit.
//  Sits directly downstream of the ALU and alongside the decoder in the single-cycle ARM datapath.
// PARAMETERS
//  FLAGS_RST  4'b0000  reset value of the {N,Z,C,V} flag register
//  CNT_W      32       width of the performance counters (used only when COND_PERF_CNT_EN is defined)
// PORTS
//  clk          in   1      single clock; all state updates on the rising edge
//  reset        in   1      synchronous, active-high reset
//  InstrValid   in   1      current instruction is real; 0 = bubble/stall, so no commit and no state change
//  Cond         in   4      instruction condition field [31:28]
//  ALUFlags     in   4      {N,Z,C,V} from the ALU for the current instruction
//  FlagW        in   2      [1]=write N,Z; [0]=write C,V (from the decoder)
//  PCS          in   1      instruction writes PC (branch or Rd==R15)
//  RegW         in   1      instruction writes the register file
//  MemW         in   1      instruction writes memory
//  NoWrite      in   1      compare-class instruction (CMP/CMN/TST): suppress RegWrite
//  CondEx       out  1      condition passes AND InstrValid
//  PCSrc        out  1      PCS & CondEx
//  RegWrite     out  1      RegW & CondEx & ~NoWrite
//  MemWrite     out  1      MemW & CondEx
//  Flags        out  4      registered {N,Z,C,V}
//  ExecCnt      out  CNT_W  (COND_PERF_CNT_EN only) count of valid instructions that passed
//  SquashCnt    out  CNT_W  (COND_PERF_CNT_EN only) count of valid instructions that failed
// BEHAVIOUR
//  - Condition evaluation is combinational on the registered Flags, never on the same-cycle ALUFlags.
//  - Condition encodings:
//      0000 EQ Z;  0001 NE !Z;  0010 CS C;  0011 CC !C;  0100 MI N;  0101 PL !N;  0110 VS V;  0111 VC !V
//      1000 HI C&!Z;  1001 LS !C|Z;  1010 GE N==V;  1011 LT N!=V;  1100 GT !Z&(N==V);  1101 LE Z|(N!=V)
//      1110 AL 1;  1111 NV 0 (reserved; always fails)
//  - Flag update at the clock edge:
//      Flags[3:2] <= ALUFlags[3:2] when FlagW[1]&CondEx
//      Flags[1:0] <= ALUFlags[1:0] when FlagW[0]&CondEx
//      Halves not written keep their value.
//  - A failed condition or InstrValid=0 leaves Flags unchanged and drives PCSrc/RegWrite/MemWrite/CondEx to 0.
//  - Latency: strobes are combinational (0 cycles). Flags become visible to the next instruction (1 cycle).
//  - Reset (synchronous, overrides all other inputs in that cycle): Flags<=FLAGS_RST; counters<=0.
//    Combinational outputs follow their inputs with Flags=FLAGS_RST.
//  - Reset asserted mid-stream discards any flag write pending that cycle.
//  - FlagW=2'b11 writes all four flags from the same ALUFlags sample.
// CONFIGURATION
//  - Macro COND_PERF_CNT_EN defined:
//      ExecCnt/SquashCnt ports exist.
//      Per valid cycle, exactly one counter increments: ExecCnt if CondEx, else SquashCnt.
//      Counters saturate at all-ones (no wrap). InstrValid=0 increments neither.
//  - Macro undefined: no counter ports and no counter logic; all other behaviour is identical.
// STRUCTURE
//  - Package cond_pkg:
//      cond_e enum (EQ..NV, 4-bit)
//      localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//      flagw_t 2-bit typedef with FLAGW_NZ=2'b10 and FLAGW_CV=2'b01
//  - Sub-module cond_check: purely combinational (Cond, Flags) -> pass.
//    Instantiated once; the top holds the registers, strobe gating and the optional counters.
// TESTING
//  1 Reset, then Cond=EQ, RegW=1, InstrValid=1 -> Flags=0000, CondEx=0, RegWrite=0.
//  2 Cond=AL, FlagW=11, ALUFlags=0100, NoWrite=1 -> RegWrite=0. Next cycle Flags=0100; Cond=EQ, RegW=1 -> RegWrite=1.
//  3 Flags=0100, Cond=AL, FlagW=10, ALUFlags=1011 -> Flags=1000 (C,V retained at 00).
//  4 Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111 -> CondEx=0 and Flags stays 0000.
//    Repeat with Cond=AL, InstrValid=0 -> Flags stays 0000.
//  5 Flags=1001 -> GE pass, LT fail. Flags=1000 -> LT pass.
//    PCS=1, Cond=LT -> PCSrc=1. Cond=NV -> all strobes 0.
//  6 (COND_PERF_CNT_EN) 3 passing + 2 failing valid cycles + 1 bubble -> ExecCnt=3, SquashCnt=2.
//    Reset in the next cycle -> both 0. With CNT_W=2, 5 passes -> ExecCnt=3 (saturated).

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution logic.
//   cond_e  : ARM condition field encodings (instruction bits [31:28])
//   FLAG_*  : bit positions of N, Z, C, V inside the 4-bit flag vector
//   flagw_t : decoder flag-write control, one bit per flag pair
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] flagw_t;

  localparam flagw_t FLAGW_NZ = 2'b10;
  localparam flagw_t FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator.
// Ports:
//   cond  in  4  condition field of the current instruction
//   flags in  4  architectural {N,Z,C,V}
//   pass  out 1  1 when the condition holds for the given flags
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode the condition field against the current flags; NV is reserved and never passes.
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ:      pass = z_s;
      NE:      pass = ~z_s;
      CS:      pass = c_s;
      CC:      pass = ~c_s;
      MI:      pass = n_s;
      PL:      pass = ~n_s;
      VS:      pass = v_s;
      VC:      pass = ~v_s;
      HI:      pass = c_s & ~z_s;
      LS:      pass = ~c_s | z_s;
      GE:      pass = (n_s == v_s);
      LT:      pass = (n_s != v_s);
      GT:      pass = ~z_s & (n_s == v_s);
      LE:      pass = z_s | (n_s != v_s);
      AL:      pass = 1'b1;
      NV:      pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_unit.sv
// Conditional-execution unit for a single-cycle ARM datapath.
// Holds the architectural {N,Z,C,V} register, evaluates the instruction
// condition against it and gates the decoder's commit strobes.
// Optional feature: define COND_PERF_CNT_EN to add saturating counters of
// passed (ExecCnt) and squashed (SquashCnt) valid instructions.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   InstrValid   instruction is real (0 = bubble, no commit, no state change)
//   Cond         condition field
//   ALUFlags     {N,Z,C,V} produced by the ALU this cycle
//   FlagW        [1] write N,Z  [0] write C,V
//   PCS/RegW/MemW/NoWrite  decoder write intents
//   CondEx/PCSrc/RegWrite/MemWrite  gated strobes (combinational)
//   Flags        registered {N,Z,C,V}
//   ExecCnt/SquashCnt (COND_PERF_CNT_EN only) performance counters
module cond_logic_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter int         CNT_W     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       InstrValid,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  logic [3:0] flags_r;
  logic [3:0] flags_nxt_s;
  logic       pass_s;
  logic       cond_ex_s;
  flagw_t     flagw_s;
  logic       wr_nz_s;
  logic       wr_cv_s;

  // Conditions are evaluated on the registered flags so an instruction never
  // sees its own ALU result.
  cond_check u_cond_check (
    .cond  (Cond),
    .flags (flags_r),
    .pass  (pass_s)
  );

  assign cond_ex_s = pass_s & InstrValid;
  assign flagw_s   = flagw_t'(FlagW);
  assign wr_nz_s   = cond_ex_s & ((flagw_s & FLAGW_NZ) != 2'b00);
  assign wr_cv_s   = cond_ex_s & ((flagw_s & FLAGW_CV) != 2'b00);

  // Merge the ALU flags into the pairs being written; unwritten pairs hold.
  always_comb begin
    flags_nxt_s = flags_r;
    if (wr_nz_s) begin
      flags_nxt_s[FLAG_N] = ALUFlags[FLAG_N];
      flags_nxt_s[FLAG_Z] = ALUFlags[FLAG_Z];
    end else begin
      flags_nxt_s[FLAG_N] = flags_r[FLAG_N];
      flags_nxt_s[FLAG_Z] = flags_r[FLAG_Z];
    end
    if (wr_cv_s) begin
      flags_nxt_s[FLAG_C] = ALUFlags[FLAG_C];
      flags_nxt_s[FLAG_V] = ALUFlags[FLAG_V];
    end else begin
      flags_nxt_s[FLAG_C] = flags_r[FLAG_C];
      flags_nxt_s[FLAG_V] = flags_r[FLAG_V];
    end
  end

  // Architectural flag register; reset discards any write pending this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= FLAGS_RST;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  // Commit strobes only fire for valid, condition-passing instructions.
  always_comb begin
    CondEx   = cond_ex_s;
    PCSrc    = PCS & cond_ex_s;
    RegWrite = RegW & cond_ex_s & ~NoWrite;
    MemWrite = MemW & cond_ex_s;
  end

  assign Flags = flags_r;

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_cnt_r;
  logic [CNT_W-1:0] squash_cnt_r;

  // Saturating counters: each valid cycle bumps exactly one of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_r   <= '0;
      squash_cnt_r <= '0;
    end else if (InstrValid) begin
      if (cond_ex_s) begin
        if (exec_cnt_r != {CNT_W{1'b1}}) begin
          exec_cnt_r <= exec_cnt_r + CNT_W'(1);
        end
      end else begin
        if (squash_cnt_r != {CNT_W{1'b1}}) begin
          squash_cnt_r <= squash_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign ExecCnt   = exec_cnt_r;
  assign SquashCnt = squash_cnt_r;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Self-checking bench for cond_logic_unit: directed steps followed by
// random instructions compared against a flag-level reference model.
module tb_cond_logic_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       InstrValid = 1'b0;
  logic [3:0] Cond = 4'b0000;
  logic [3:0] ALUFlags = 4'b0000;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0;
  logic       RegW = 1'b0;
  logic       MemW = 1'b0;
  logic       NoWrite = 1'b0;
  logic       CondEx;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
  logic [31:0] ExecCnt;
  logic [31:0] SquashCnt;
  logic [1:0]  ExecCnt2;
  logic [1:0]  SquashCnt2;
  int unsigned m_exec = 0;
  int unsigned m_squash = 0;
`endif

  int checks = 0;
  int fails  = 0;
  logic [3:0] mf = 4'b0000;   // model flags {N,Z,C,V}

  always #5 clk = ~clk;

  cond_logic_unit #(.FLAGS_RST(4'b0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .CondEx(CondEx), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
`ifdef COND_PERF_CNT_EN
    , .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
`endif
  );

`ifdef COND_PERF_CNT_EN
  logic       s_condex, s_pcsrc, s_regwrite, s_memwrite;
  logic [3:0] s_flags;
  cond_logic_unit #(.FLAGS_RST(4'b0000), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .CondEx(s_condex), .PCSrc(s_pcsrc),
    .RegWrite(s_regwrite), .MemWrite(s_memwrite), .Flags(s_flags),
    .ExecCnt(ExecCnt2), .SquashCnt(SquashCnt2)
  );
`endif

  // Reference: ARM conditions come in complementary pairs; the odd code is the
  // negation of the even one (AL/NV included).
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction: drive, check strobes mid-cycle, clock, check flags.
  task automatic step(input logic v, input logic [3:0] c, input logic [3:0] af,
                      input logic [1:0] fw, input logic pcs, input logic rw,
                      input logic mw, input logic nw, input logic rst);
    logic ex;
    InstrValid = v; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; reset = rst;
    #1;
    ex = v && ref_pass(c, mf);
    chk("CondEx", {31'd0, CondEx}, {31'd0, ex});
    chk("PCSrc", {31'd0, PCSrc}, {31'd0, pcs && ex});
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, rw && ex && !nw});
    chk("MemWrite", {31'd0, MemWrite}, {31'd0, mw && ex});
    @(posedge clk);
    if (rst) begin
      mf = 4'b0000;
`ifdef COND_PERF_CNT_EN
      m_exec = 0; m_squash = 0;
`endif
    end else begin
      if (ex && fw[1]) mf[3:2] = af[3:2];
      if (ex && fw[0]) mf[1:0] = af[1:0];
`ifdef COND_PERF_CNT_EN
      if (v && ex) m_exec++;
      else if (v) m_squash++;
`endif
    end
    #1;
    chk("Flags", {28'd0, Flags}, {28'd0, mf});
`ifdef COND_PERF_CNT_EN
    chk("ExecCnt", ExecCnt, m_exec);
    chk("SquashCnt", SquashCnt, m_squash);
`endif
  endtask

  initial begin
    @(posedge clk); #1;
    // Test 1: reset, then EQ with Z=0 fails
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_flags", {28'd0, Flags}, 32'h0);
    InstrValid = 1'b1; Cond = 4'b0000; RegW = 1'b1; reset = 1'b0; #1;
    chk("t1_condex", {31'd0, CondEx}, 32'h0);
    chk("t1_regwrite", {31'd0, RegWrite}, 32'h0);
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Test 2: compare-class write of Z, then EQ passes
    step(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_flags", {28'd0, Flags}, 32'h4);
    InstrValid = 1'b1; Cond = 4'b0000; RegW = 1'b1; NoWrite = 1'b0; FlagW = 2'b00; #1;
    chk("t2_regwrite", {31'd0, RegWrite}, 32'h1);
    // Test 3: only N,Z written
    step(1'b1, 4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_flags", {28'd0, Flags}, 32'h8);
    // Test 4: failing condition and bubble leave flags alone
    step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_fail_flags", {28'd0, Flags}, 32'h0);
    step(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_bubble_flags", {28'd0, Flags}, 32'h0);
    // Test 5: signed conditions, PC gating, NV
    step(1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    InstrValid = 1'b1; Cond = 4'b1011; PCS = 1'b1; FlagW = 2'b00; #1;
    chk("t5_lt_pcsrc", {31'd0, PCSrc}, 32'h1);
    step(1'b1, 4'b1011, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_nv_flags", {28'd0, Flags}, 32'h8);

`ifdef COND_PERF_CNT_EN
    // Test 6: counters
    step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_exec", ExecCnt, 32'd3);
    chk("t6_squash", SquashCnt, 32'd2);
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_exec_rst", ExecCnt, 32'd0);
    chk("t6_squash_rst", SquashCnt, 32'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_sat", {30'd0, ExecCnt2}, 32'd3);
    chk("t6_sat_squash", {30'd0, SquashCnt2}, 32'd0);
`endif

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)),
           4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           ($urandom_range(39, 0) == 0));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
